// File: rtl/break_unit_pkg.sv
// break_unit_pkg: register word indices, CTRL bit positions and FSM state encoding for break_unit
package break_unit_pkg;
  localparam logic [2:0] W_CTRL   = 3'd4;
  localparam logic [2:0] W_STATUS = 3'd5;
  localparam logic [2:0] W_STEP   = 3'd6;
  localparam int CTRL_GEN    = 0;
  localparam int CTRL_RESUME = 1;
  localparam logic [1:0] S_RUN    = 2'd0;
  localparam logic [1:0] S_HALTED = 2'd1;
  localparam logic [1:0] S_SKIP   = 2'd2;
endpackage

// File: rtl/break_unit_bp_compare.sv
// bp_compare: one PC breakpoint comparator (bp_addr, bp_en, pc -> match on word address)
module bp_compare #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:2] bp_addr,
  input  logic            bp_en,
  input  logic [XLEN-1:0] pc,
  output logic            match
);
  assign match = bp_en && bp_addr == pc[XLEN-1:2];
endmodule

// File: rtl/break_unit.sv
// break_unit: PC breakpoint unit that freezes the auto clock via oBreak
// Ports: CLK/Reset (async active-high), iPC/iInstrValid retire stream,
// iAddr/iWrite/iWriteData/oReadData register port, oBreak halt level.
// Optional single-step counter is enabled by defining BREAK_STEP_EN.
module break_unit
  import break_unit_pkg::*;
#(
  parameter int NUM_BP = 4,
  parameter int XLEN   = 32
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic [XLEN-1:0] iPC,
  input  logic            iInstrValid,
  input  logic [2:0]      iAddr,
  input  logic            iWrite,
  input  logic [XLEN-1:0] iWriteData,
  output logic [XLEN-1:0] oReadData,
  output logic            oBreak
);
  logic [XLEN-1:2] bp_addr [NUM_BP];
  logic [NUM_BP-1:0] bp_en, match;
  logic [XLEN-1:0] bp_rd [4];
  logic [1:0] state;
  logic [2:0] hit_idx, low_idx;
  logic gen, hit, resume, step_exp, step_done;
  logic [15:0] cnt;
  logic [31:0] status;
  genvar i;
  for (i = 0; i < NUM_BP; i++) begin : g_cmp
    bp_compare #(.XLEN(XLEN)) u_cmp (
      .bp_addr(bp_addr[i]),
      .bp_en  (bp_en[i]),
      .pc     (iPC),
      .match  (match[i])
    );
  end
  for (i = 0; i < 4; i++) begin : g_rd
    if (i < NUM_BP) begin : g_on
      assign bp_rd[i] = {bp_addr[i], 1'b0, bp_en[i]};
    end else begin : g_off
      assign bp_rd[i] = '0;
    end
  end
  always_comb begin
    low_idx = '0;
    for (int k = NUM_BP - 1; k >= 0; k--)
      if (match[k]) low_idx = 3'(k);
  end
  assign hit    = iInstrValid && gen && state == S_RUN && |match;
  assign resume = iWrite && iAddr == W_CTRL && iWriteData[CTRL_RESUME] && state == S_HALTED;
  always_ff @(posedge CLK or posedge Reset)
    if (Reset) begin
      bp_addr <= '{default: '0};
      bp_en   <= '0;
    end else if (iWrite)
      for (int k = 0; k < NUM_BP; k++)
        if (iAddr == 3'(k)) begin
          bp_addr[k] <= iWriteData[XLEN-1:2];
          bp_en[k]   <= iWriteData[0];
        end
  always_ff @(posedge CLK or posedge Reset)
    if (Reset) begin
      state   <= S_RUN;
      gen     <= 1'b0;
      hit_idx <= '0;
    end else begin
      if (iWrite && iAddr == W_CTRL) gen <= iWriteData[CTRL_GEN];
      if (hit) hit_idx <= low_idx;
      state <= (hit || step_exp) ? S_HALTED :
               resume ? S_SKIP :
               (state == S_SKIP && iInstrValid) ? S_RUN : state;
    end
`ifdef BREAK_STEP_EN
  assign step_exp = iInstrValid && state != S_HALTED && cnt == 16'd1;
  always_ff @(posedge CLK or posedge Reset)
    if (Reset) begin
      cnt       <= '0;
      step_done <= 1'b0;
    end else begin
      cnt <= (iWrite && iAddr == W_STEP && |iWriteData[15:0]) ? iWriteData[15:0] :
             (iInstrValid && state != S_HALTED && cnt != 16'd0) ? cnt - 16'd1 : cnt;
      step_done <= step_exp ? 1'b1 : resume ? 1'b0 : step_done;
    end
`else
  assign step_exp  = 1'b0;
  assign cnt       = '0;
  assign step_done = 1'b0;
`endif
  assign status    = {cnt, 11'b0, hit_idx, step_done, state == S_HALTED};
  assign oBreak    = state == S_HALTED;
  assign oReadData = !iAddr[2] ? bp_rd[iAddr[1:0]] :
                     iAddr == W_CTRL ? XLEN'(gen) :
                     iAddr == W_STATUS ? XLEN'(status) :
                     iAddr == W_STEP ? XLEN'(cnt) : '0;
endmodule
